// File: rtl/add_sub_align_shr_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : add_sub_align_shr_pipe
//  Function : Two-stage elastic right barrel shifter with sticky generation,
//             used to align the smaller-exponent mantissa in FPU add/sub.
//             Stage 1 applies the low shift bits, stage 2 the high bits.
//  Revision : 1.0 - initial release
// ============================================================================
module add_sub_align_shr_pipe #(
  parameter int SIZE_DATA  = 32,
  parameter int SIZE_SHIFT = 8,
  parameter int SIZE_TAG   = 9,
  parameter int SPLIT      = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [SIZE_SHIFT-1:0] i_shift_number,
  input  logic [SIZE_DATA-1:0]  i_data,
  input  logic [SIZE_TAG-1:0]   i_tag,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [SIZE_DATA-1:0]  o_data,
  output logic                  o_sticky,
  output logic [SIZE_TAG-1:0]   o_tag
);

  localparam int SIZE_HI = SIZE_SHIFT - SPLIT;

  // Stage 1 registers
  logic                 s1_valid_q, s1_valid_d;
  logic [SIZE_DATA-1:0] s1_data_q,  s1_data_d;
  logic                 s1_sticky_q, s1_sticky_d;
  logic                 s1_sat_q,   s1_sat_d;
  logic [SIZE_HI-1:0]   s1_hi_q,    s1_hi_d;
  logic [SIZE_TAG-1:0]  s1_tag_q,   s1_tag_d;

  // Stage 2 registers (drive the outputs directly)
  logic                 s2_valid_q, s2_valid_d;
  logic [SIZE_DATA-1:0] s2_data_q,  s2_data_d;
  logic                 s2_sticky_q, s2_sticky_d;
  logic [SIZE_TAG-1:0]  s2_tag_q,   s2_tag_d;

  // Handshake and datapath wires
  logic                  w_s2_load;
  logic                  w_s1_load;
  logic                  w_in_fire;
  logic [SPLIT-1:0]      w_lo;
  logic [SIZE_SHIFT-1:0] w_amt;
  logic [SIZE_DATA-1:0]  w_lo_mask;
  logic [SIZE_DATA-1:0]  w_hi_mask;

  // Elastic control: a stage loads when empty or when its content moves on.
  // o_ready depends on i_ready combinationally, but the data path is fully registered.
  always_comb begin
    w_s2_load = !s2_valid_q || i_ready;
    w_s1_load = !s1_valid_q || w_s2_load;
    w_in_fire = i_valid && w_s1_load;
    o_ready   = w_s1_load;
  end

  // Shift amounts and the masks selecting the bits each stage discards
  always_comb begin
    w_lo      = i_shift_number[SPLIT-1:0];
    w_amt     = {s1_hi_q, {SPLIT{1'b0}}};
    w_lo_mask = ~({SIZE_DATA{1'b1}} << w_lo);
    w_hi_mask = ~({SIZE_DATA{1'b1}} << w_amt);
  end

  // Stage 1 next state: fine shift, partial sticky, saturation detect
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_sticky_d = s1_sticky_q;
    s1_sat_d    = s1_sat_q;
    s1_hi_d     = s1_hi_q;
    s1_tag_d    = s1_tag_q;
    if (w_s1_load) begin
      s1_valid_d = w_in_fire;
      if (w_in_fire) begin
        s1_data_d   = i_data >> w_lo;
        s1_sticky_d = |(i_data & w_lo_mask);
        // Any shift of the full width or more flushes the whole mantissa
        s1_sat_d    = 32'(i_shift_number) >= 32'(SIZE_DATA);
        s1_hi_d     = i_shift_number[SIZE_SHIFT-1:SPLIT];
        s1_tag_d    = i_tag;
      end
    end
  end

  // Stage 2 next state: coarse shift and final sticky
  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_data_d   = s2_data_q;
    s2_sticky_d = s2_sticky_q;
    s2_tag_d    = s2_tag_q;
    if (w_s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_tag_d = s1_tag_q;
        if (s1_sat_q) begin
          // Stage-1 data plus its partial sticky together cover every input bit
          s2_data_d   = '0;
          s2_sticky_d = s1_sticky_q || (|s1_data_q);
        end else begin
          s2_data_d   = s1_data_q >> w_amt;
          s2_sticky_d = s1_sticky_q || (|(s1_data_q & w_hi_mask));
        end
      end
    end
  end

  // Pipeline registers with asynchronous active-low reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_sticky_q <= 1'b0;
      s1_sat_q    <= 1'b0;
      s1_hi_q     <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_sticky_q <= 1'b0;
      s2_tag_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_sticky_q <= s1_sticky_d;
      s1_sat_q    <= s1_sat_d;
      s1_hi_q     <= s1_hi_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_sticky_q <= s2_sticky_d;
      s2_tag_q    <= s2_tag_d;
    end
  end

  // Output mapping
  always_comb begin
    o_valid  = s2_valid_q;
    o_data   = s2_data_q;
    o_sticky = s2_sticky_q;
    o_tag    = s2_tag_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_add_sub_align_shr_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add_sub_align_shr_pipe
//  Function : Self-checking bench for add_sub_align_shr_pipe against a
//             queue-based reference model of the shift/sticky behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_add_sub_align_shr_pipe;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  i_shift_number;
  logic [31:0] i_data;
  logic [8:0]  i_tag;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic        o_sticky;
  logic [8:0]  o_tag;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Expected beats: {tag, data, sticky}
  logic [41:0] exp_q[$];

  add_sub_align_shr_pipe #(
    .SIZE_DATA (32),
    .SIZE_SHIFT(8),
    .SIZE_TAG  (9),
    .SPLIT     (3)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_shift_number(i_shift_number),
    .i_data        (i_data),
    .i_tag         (i_tag),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_data        (o_data),
    .o_sticky      (o_sticky),
    .o_tag         (o_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: place the mantissa above a 32-bit fraction field, shift, and
  // read the integer part as data and any surviving fraction bit as sticky.
  function automatic logic [32:0] model(input logic [31:0] d, input int s);
    logic [63:0] wide;
    if (s >= 32) return {32'h0, |d};
    wide = {d, 32'h0} >> s;
    return {wide[63:32], |wide[31:0]};
  endfunction

  // Scoreboard: at each falling edge, evaluate the handshakes that the next
  // rising edge will complete.
  logic        prev_stall = 1'b0;
  logic [41:0] prev_out;
  int          out_beats = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", 64'(o_valid), 64'd1);
        check("stall_hold_beat", 64'({o_tag, o_data, o_sticky}), 64'(prev_out));
      end
      if (o_valid && i_ready) begin
        out_beats++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'({o_tag, o_data, o_sticky}), 64'h0);
        end else begin
          logic [41:0] e;
          e = exp_q.pop_front();
          check("out_data", 64'(o_data), 64'(e[32:1]));
          check("out_sticky", 64'(o_sticky), 64'(e[0]));
          check("out_tag", 64'(o_tag), 64'(e[41:33]));
        end
      end
      if (i_valid && o_ready)
        exp_q.push_back({i_tag, model(i_data, int'(i_shift_number))});
      prev_stall = o_valid && !i_ready;
      prev_out   = {o_tag, o_data, o_sticky};
    end
  end

  // One isolated beat with i_ready held high; checks exact latency and literal result.
  task automatic send_check(input logic [31:0] d, input logic [7:0] s,
                            input logic [31:0] ed, input logic es, input logic [8:0] t);
    i_ready = 1'b1;
    i_valid = 1'b1; i_data = d; i_shift_number = s; i_tag = t;
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("lat_not_yet", 64'(o_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_valid", 64'(o_valid), 64'd1);
    check("lit_data", 64'(o_data), 64'(ed));
    check("lit_sticky", 64'(o_sticky), 64'(es));
    check("lit_tag", 64'(o_tag), 64'(t));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] d4[8];
    int c, b, cyc;
    logic [32:0] m;

    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_data = '0; i_shift_number = '0; i_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_data", 64'(o_data), 64'd0);
    check("rst_o_sticky", 64'(o_sticky), 64'd0);
    check("rst_o_tag", 64'(o_tag), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pin the reference model with hand-computed values
    m = model(32'h1234_5678, 0);   check("model_t1", 64'(m), 64'({32'h1234_5678, 1'b0}));
    m = model(32'h8000_0001, 4);   check("model_t2a", 64'(m), 64'({32'h0800_0000, 1'b1}));
    m = model(32'h0000_00F0, 4);   check("model_t2b", 64'(m), 64'({32'h0000_000F, 1'b0}));
    m = model(32'hFFFF_FFFF, 31);  check("model_t3a", 64'(m), 64'({32'h0000_0001, 1'b1}));
    m = model(32'h0000_0001, 40);  check("model_t3b", 64'(m), 64'({32'h0, 1'b1}));
    m = model(32'h0, 255);         check("model_t3c", 64'(m), 64'({32'h0, 1'b0}));

    // T1-T3 directed literal beats
    send_check(32'h1234_5678, 8'd0,   32'h1234_5678, 1'b0, 9'h011);
    send_check(32'h8000_0001, 8'd4,   32'h0800_0000, 1'b1, 9'h022);
    send_check(32'h0000_00F0, 8'd4,   32'h0000_000F, 1'b0, 9'h133);
    send_check(32'hFFFF_FFFF, 8'd31,  32'h0000_0001, 1'b1, 9'h044);
    send_check(32'h8000_0000, 8'd31,  32'h0000_0001, 1'b0, 9'h055);
    send_check(32'h0000_0001, 8'd40,  32'h0,         1'b1, 9'h066);
    send_check(32'h0,         8'd255, 32'h0,         1'b0, 9'h077);
    send_check(32'h8000_0000, 8'd255, 32'h0,         1'b1, 9'h188);
    send_check(32'hF000_0000, 8'd32,  32'h0,         1'b1, 9'h099);

    // T4: 8-beat stream with downstream stalled during cycles 3..6
    foreach (d4[k]) d4[k] = $urandom;
    c = 0; b = 0;
    while (b < 8 && c < 60) begin
      i_ready = !(c >= 3 && c <= 6);
      i_valid = 1'b1; i_data = d4[b]; i_shift_number = 8'(b * 5); i_tag = 9'(b);
      @(negedge clk);
      if (c == 5) check("t4_o_ready_stalled", 64'(o_ready), 64'd0);
      if (o_ready) b++;
      @(posedge clk); #1;
      c++;
    end
    check("t4_all_sent", 64'(b), 64'd8);
    i_valid = 1'b0; i_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t4_drained", 64'(exp_q.size()), 64'd0);

    // T5: randomized traffic
    b = 0; cyc = 0;
    while (b < 10000 && cyc < 60000) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0: i_data = 32'h0;
        1: i_data = 32'hFFFF_FFFF;
        2: i_data = 32'h1 << $urandom_range(0, 31);
        default: i_data = $urandom;
      endcase
      i_shift_number = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 255));
      i_tag = 9'($urandom);
      @(negedge clk);
      if (i_valid && o_ready) b++;
      @(posedge clk); #1;
      cyc++;
    end
    check("t5_beats_sent", 64'(b), 64'd10000);
    i_valid = 1'b0; i_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("t5_drained", 64'(exp_q.size()), 64'd0);

    // T6: reset with two beats in flight
    i_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_valid = 1'b1; i_data = 32'hDEAD_0000 | 32'(k); i_shift_number = 8'd1; i_tag = 9'h1AA;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    check("t6_full_before_rst", 64'(o_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_o_valid", 64'(o_valid), 64'd0);
    check("t6_rst_o_data", 64'(o_data), 64'd0);
    check("t6_rst_o_sticky", 64'(o_sticky), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("t6_no_stale", 64'(o_valid), 64'd0);
    end
    send_check(32'h0000_0F00, 8'd8, 32'h0000_000F, 1'b0, 9'h0BB);
    repeat (2) @(posedge clk);
    #1;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
